// File: rtl/regfile_pingpong.sv
// regfile_pingpong: double-buffered register file for the PE operand path.
// The producer fills the current write bank one multi-word transfer block per
// cycle and commits it; the consumer reads the committed bank through
// NUM_READ_PORTS random-access ports and then releases it.
//
// Ports:
//   clock, resetn          sole clock (rising edge), synchronous active-low reset
//   writeValid/writeReady  transfer-block handshake; ready while write bank not full
//   writeAddrBlock         block index; lane i lands at word blk*WRITE_LANES+i
//   writeData              WRITE_LANES packed words, lane 0 in the low bits
//   writeCommit            with an accepted block: hand the bank to the reader
//   readBankValid          a committed bank is available to the reader
//   readRelease            reader is done with the current read bank
//   readAddr/readData      per-port word address / data, one cycle latency
//   bankCount              number of full banks (0..2)
module regfile_pingpong #(
  parameter int PORT_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int WRITE_LANES    = 2,
  parameter int NUM_READ_PORTS = 2,
  localparam int LANE_BITS     = $clog2(WRITE_LANES),
  localparam int BLK_WIDTH     = ((ADDR_WIDTH - LANE_BITS) < 1) ? 1 : (ADDR_WIDTH - LANE_BITS)
) (
  input  logic                                 clock,
  input  logic                                 resetn,
  input  logic                                 writeValid,
  output logic                                 writeReady,
  input  logic [BLK_WIDTH-1:0]                 writeAddrBlock,
  input  logic [WRITE_LANES*PORT_WIDTH-1:0]    writeData,
  input  logic                                 writeCommit,
  output logic                                 readBankValid,
  input  logic                                 readRelease,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readAddr,
  output logic [NUM_READ_PORTS*PORT_WIDTH-1:0] readData,
  output logic [1:0]                           bankCount
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [PORT_WIDTH-1:0] mem_q [2*DEPTH];
  logic [1:0]            full_q, full_d;
  logic                  wr_bank_q, wr_bank_d;
  logic                  rd_bank_q, rd_bank_d;
  logic                  rd_bank_cap_q;
  logic [ADDR_WIDTH-1:0] raddr_q [NUM_READ_PORTS];

  logic                  wr_accept;
  logic                  rd_release;
  logic [ADDR_WIDTH-1:0] blk_base;

  assign writeReady    = ~full_q[wr_bank_q];
  assign readBankValid = full_q[rd_bank_q];
  assign bankCount     = {full_q[0] & full_q[1], full_q[0] ^ full_q[1]};

  assign wr_accept  = writeValid & writeReady;
  assign rd_release = readRelease & readBankValid;

  // First word of the addressed block; lanes are OR-ed into the low bits.
  assign blk_base = ADDR_WIDTH'(writeAddrBlock) << LANE_BITS;

  // Commit and release always target different banks (one needs the bank
  // empty, the other needs it full), so both updates can apply together.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    if (wr_accept && writeCommit) begin
      full_d[wr_bank_q] = 1'b1;
      wr_bank_d         = ~wr_bank_q;
    end
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int w = 0; w < 2*DEPTH; w++) begin
        mem_q[w] <= '0;
      end
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      rd_bank_cap_q <= 1'b0;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        raddr_q[p] <= '0;
      end
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      // The bank is captured before a same-cycle release takes effect, so
      // addresses presented with the release still read the released bank.
      rd_bank_cap_q <= rd_bank_q;
      for (int p = 0; p < NUM_READ_PORTS; p++) begin
        raddr_q[p] <= readAddr[p*ADDR_WIDTH +: ADDR_WIDTH];
      end
      if (wr_accept) begin
        for (int l = 0; l < WRITE_LANES; l++) begin
          mem_q[{wr_bank_q, blk_base | ADDR_WIDTH'(l)}] <= writeData[l*PORT_WIDTH +: PORT_WIDTH];
        end
      end
    end
  end

  always_comb begin
    readData = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      readData[p*PORT_WIDTH +: PORT_WIDTH] = mem_q[{rd_bank_cap_q, raddr_q[p]}];
    end
  end

endmodule
